// File: rtl/poly_pointwise_mont_ctrl.sv
// Pointwise NTT-domain multiply sequencer: reads coefficient pairs, forms the
// 64-bit signed product, hands it to the Montgomery reducer, writes the result back.
module poly_pointwise_mont_ctrl #(
    parameter int N      = 256,
    parameter int ADDR_W = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic signed [31:0]       a_coef,
    input  logic signed [31:0]       b_coef,
    output logic                     red_start,
    output logic signed [63:0]       red_a,
    input  logic                     red_done,
    input  logic signed [31:0]       red_t,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic signed [31:0]       wr_data
);

    typedef enum logic [2:0] {
        IDLE, READ, MUL, RSTART, RWAIT, WRITE, FINISH
    } state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   index;
    logic                last;
    logic signed [63:0]  a_ext, b_ext;

    assign last  = (index == ADDR_W'(N - 1));
    assign a_ext = {{32{a_coef[31]}}, a_coef};
    assign b_ext = {{32{b_coef[31]}}, b_coef};

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = READ;
            READ:    state_next = MUL;
            MUL:     state_next = RSTART;
            RSTART:  state_next = RWAIT;
            RWAIT:   if (red_done) state_next = WRITE;
            WRITE:   state_next = last ? FINISH : READ;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        red_start = 1'b0;
        wr_en     = 1'b0;
        rd_addr   = index;
        wr_addr   = index;
        case (state)
            READ, MUL, RWAIT: busy = 1'b1;
            RSTART: begin
                busy      = 1'b1;
                red_start = 1'b1;
            end
            WRITE: begin
                busy  = 1'b1;
                wr_en = 1'b1;
            end
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end

    // red_a only loads in MUL, so it is frozen while the reducer is working
    always_ff @(posedge clock) begin
        if (reset) begin
            index   <= '0;
            red_a   <= '0;
            wr_data <= '0;
        end else begin
            case (state)
                MUL:     red_a <= a_ext * b_ext;
                RWAIT:   if (red_done) wr_data <= red_t;
                WRITE:   if (!last) index <= index + 1'b1;
                FINISH:  index <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_pointwise_mont_ctrl.sv
// Bench for poly_pointwise_mont_ctrl: operand/result RAMs, a Montgomery reducer
// stub with programmable latency, and a modular-arithmetic reference check.
module tb_poly_pointwise_mont_ctrl;
    localparam int          N    = 256;
    localparam int          AW   = 8;
    localparam longint      Q    = 8380417;
    localparam longint      R2   = 4193792;
    localparam logic [31:0] QINV = 32'd58728449;

    logic clock, reset, start, busy, done, red_start, red_done, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic signed [31:0] a_coef, b_coef, red_t, wr_data;
    logic signed [63:0] red_a;

    poly_pointwise_mont_ctrl #(.N(N), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .rd_addr(rd_addr), .a_coef(a_coef), .b_coef(b_coef),
        .red_start(red_start), .red_a(red_a), .red_done(red_done), .red_t(red_t),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int red_delay = 3;
    int cnt;
    bit pend;
    logic signed [31:0] a_mem [N];
    logic signed [31:0] b_mem [N];
    logic signed [31:0] res_mem [N];
    logic signed [63:0] ra_log [N];
    int wr_cnt, wr_total, done_cnt, busy_cnt;
    bit in_wait;
    logic signed [63:0] held;

    typedef struct {
        logic signed [31:0] a;
        logic signed [31:0] b;
        longint             ra;
        bit                 exact;
        logic signed [31:0] wr;
    } vec_t;
    vec_t tbl [8];

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        a_coef <= a_mem[rd_addr];
        b_coef <= b_mem[rd_addr];
        if (wr_en) res_mem[wr_addr] <= wr_data;
    end

    // Dilithium-style signed Montgomery reduction: returns x*2^-32 mod q in (-q,q)
    function automatic logic signed [31:0] mont(input logic signed [63:0] x);
        logic [31:0] lo;
        logic signed [31:0] t;
        logic signed [63:0] u;
        lo = x[31:0] * QINV;
        t  = signed'(lo);
        u  = x - longint'(t) * Q;
        return u[63:32];
    endfunction

    always @(posedge clock) begin
        red_done <= 1'b0;
        if (reset) begin
            pend  <= 1'b0;
            cnt   <= 0;
            red_t <= '0;
        end else if (red_start) begin
            pend  <= 1'b1;
            cnt   <= red_delay - 1;
            red_t <= mont(red_a);
        end else if (pend) begin
            if (cnt <= 1) begin
                red_done <= 1'b1;
                pend     <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    function automatic longint md(input longint x);
        return ((x % Q) + Q) % Q;
    endfunction

    // r must satisfy r*2^32 == p (mod q) and lie strictly inside (-q,q)
    function automatic longint congr(input longint p, input longint r);
        return (r > -Q && r < Q && (md(r) * R2) % Q == md(p)) ? 64'd1 : 64'd0;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        longint p;
        @(negedge clock);
        if (reset) begin
            in_wait = 1'b0;
        end else begin
            if (red_start) begin
                chk("red_start single", longint'(in_wait), 0);
                if (wr_cnt < N) begin
                    p = longint'(a_mem[wr_cnt]) * longint'(b_mem[wr_cnt]);
                    chk("red_a product", red_a, p);
                    ra_log[wr_cnt] = red_a;
                end
                held    = red_a;
                in_wait = 1'b1;
            end else if (in_wait) begin
                chk("red_a hold", red_a, held);
                chk("wr_en in wait", longint'(wr_en), 0);
                if (red_done) in_wait = 1'b0;
            end
            if (wr_en) begin
                chk("wr_addr", longint'(wr_addr), longint'(wr_cnt));
                if (wr_cnt < N) begin
                    p = longint'(a_mem[wr_cnt]) * longint'(b_mem[wr_cnt]);
                    chk("wr_data mod q", congr(p, longint'(wr_data)), 1);
                end
                wr_cnt++;
                wr_total++;
            end
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, " busy"},      longint'(busy), 0);
        chk({nm, " done"},      longint'(done), 0);
        chk({nm, " red_start"}, longint'(red_start), 0);
        chk({nm, " wr_en"},     longint'(wr_en), 0);
        chk({nm, " rd_addr"},   longint'(rd_addr), 0);
        chk({nm, " wr_addr"},   longint'(wr_addr), 0);
        chk({nm, " red_a"},     red_a, 0);
        chk({nm, " wr_data"},   longint'(wr_data), 0);
    endtask

    task automatic do_run(input int d, input int poke);
        int s, t;
        bit poked;
        red_delay = d;
        wr_cnt = 0; done_cnt = 0; busy_cnt = 0; in_wait = 1'b0; poked = 1'b0;
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
        t = 0;
        while (!done && t < 40000) begin
            if (poke >= 0 && !poked && wr_cnt == poke) begin
                start = 1'b1;
                poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            t++;
        end
        start = 1'b0;
        chk("done latency", longint'(cyc - s), longint'((4 + d) * N + 1));
        repeat (4) tick();
        chk("done pulses", longint'(done_cnt), 1);
        chk("write count", longint'(wr_cnt), longint'(N));
        chk("busy cycles", longint'(busy_cnt), longint'((4 + d) * N));
    endtask

    task automatic load_random();
        for (int i = 0; i < N; i++) begin
            a_mem[i] = int'($urandom_range(0, 16760832)) - 8380416;
            b_mem[i] = int'($urandom_range(0, 16760832)) - 8380416;
        end
    endtask

    initial begin
        int t, hold_w, hold_d;
        tbl[0] = '{32'sd8380416,  32'sd8380416, 64'sh00003FE004000000,  1'b0, 32'sd0};
        tbl[1] = '{32'sd5,        32'sd4193792, 64'sd20968960,          1'b1, 32'sd5};
        tbl[2] = '{-32'sd1,       32'sd4193792, -64'sd4193792,          1'b1, -32'sd1};
        tbl[3] = '{32'sd0,        32'sd12345,   64'sd0,                 1'b1, 32'sd0};
        tbl[4] = '{-32'sd5,       32'sd4193792, -64'sd20968960,         1'b1, -32'sd5};
        tbl[5] = '{32'sd1000000,  32'sd4193792, 64'sd4193792000000,     1'b1, 32'sd1000000};
        tbl[6] = '{-32'sd8380416, 32'sd8380416, -64'sh00003FE004000000, 1'b0, 32'sd0};
        tbl[7] = '{32'sd1,        32'sd1,       64'sd1,                 1'b0, 32'sd0};

        reset = 1'b1; start = 1'b0; wr_total = 0;
        for (int i = 0; i < N; i++) begin
            a_mem[i] = i;
            b_mem[i] = 32'sd4193792;
        end
        repeat (3) @(negedge clock);
        check_zero("reset");
        reset = 1'b0;
        tick();

        // a*2^32 mod q reduces back to a
        do_run(3, -1);
        for (int k = 0; k < N; k++) chk("identity", longint'(res_mem[k]), longint'(k));

        for (int k = 0; k < N; k++) a_mem[k] = -32'sd1;
        do_run(3, -1);
        for (int k = 0; k < N; k++) begin
            chk("neg one wr", longint'(res_mem[k]), -1);
            chk("neg one red_a", ra_log[k], -64'sd4193792);
        end

        // table vectors up front, random tail, slow reducer, stray start mid-run
        load_random();
        for (int i = 0; i < 8; i++) begin
            a_mem[i] = tbl[i].a;
            b_mem[i] = tbl[i].b;
        end
        do_run(10, 50);
        for (int i = 0; i < 8; i++) begin
            chk("table red_a", ra_log[i], tbl[i].ra);
            if (tbl[i].exact) chk("table wr_data", longint'(res_mem[i]), longint'(tbl[i].wr));
        end

        // abort during coefficient 100
        load_random();
        red_delay = 3; wr_cnt = 0; done_cnt = 0; in_wait = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        t = 0;
        while (wr_cnt < 100 && t < 5000) begin
            tick();
            t++;
        end
        chk("reached coef 100", longint'(wr_cnt), 100);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_zero("midrun reset");
        reset = 1'b0;
        hold_w = wr_total;
        hold_d = done_cnt;
        repeat (40) tick();
        chk("no write after abort", longint'(wr_total), longint'(hold_w));
        chk("no done after abort", longint'(done_cnt), longint'(hold_d));

        load_random();
        do_run(3, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
